// File: rtl/jtag_pkg.sv
// jtag_pkg: shared constants and helpers for the JTAG register bank.
//   JTAG_ID_VERSION - version byte reported in the ID word
//   IDREG_SIZE      - width of the ID shift register
//   addr_width()    - index width for a bank of n registers; the all-ones
//                     index is always left unused and reserved for ID/overrun
package jtag_pkg;

  localparam logic [7:0] JTAG_ID_VERSION = 8'h02;
  localparam int         IDREG_SIZE      = 24;

  function automatic int addr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jtag_bit_counter.sv
// jtag_bit_counter: counts shifted bits within a word and flags the SDR edge
// on which a full word is complete.
// Optional feature: JTAG_REGBANK_BURST_EN - when defined the counter keeps
// committing every REGISTER_SIZE bits; otherwise it stops after the first.
// Ports:
//   clk    - TCK
//   rst_n  - synchronous active-low reset
//   clear  - restart counting (capture-DR)
//   step   - one armed shift-DR edge
//   commit - high during the step that completes a word
module jtag_bit_counter #(
  parameter int REGISTER_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  output logic commit
);

  localparam int CW = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;

  logic [CW-1:0] count_r;
  logic          done_r;

  // Word-complete flag for the current shift edge
  always_comb begin
    if (step && !done_r && (count_r == CW'(REGISTER_SIZE - 1))) begin
      commit = 1'b1;
    end else begin
      commit = 1'b0;
    end
  end

  // Bit counter; done_r freezes it after a commit in single-word mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
      done_r  <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
      done_r  <= 1'b0;
    end else if (step && !done_r) begin
      if (commit) begin
        count_r <= '0;
`ifdef JTAG_REGBANK_BURST_EN
        done_r  <= 1'b0;
`else
        done_r  <= 1'b1;
`endif
      end else begin
        count_r <= count_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/jtag_regbank.sv
// jtag_regbank: bank of NUMBER_OF_REGISTERS registers, each REGISTER_SIZE
// bits, read and written through a JTAG data register scan.
// Optional feature: JTAG_REGBANK_BURST_EN - multi-word scans; each commit
// also reloads the work register from the next read location.
// Ports:
//   iTCK, iRST_N          - clock and synchronous active-low reset
//   iTDI / oTDO           - serial data in / out (oTDO combinational)
//   iSTATE_CDR/SDR/UDR    - capture, shift, update DR state flags
//   iADDRESS              - {enable, write index, read index}
//   iDATA                 - capture sources, register i at [i*RS +: RS]
//   oDATA                 - memory contents, same packing as iDATA
//   oWRITE_STROBE         - one-cycle pulse per register written
//   oREAD_STROBE          - one-cycle pulse per register captured
module jtag_regbank
  import jtag_pkg::*;
#(
  parameter int  REGISTER_SIZE       = 8,
  parameter int  NUMBER_OF_REGISTERS = 7,
  localparam int ADDRESS_WIDTH       = addr_width(NUMBER_OF_REGISTERS)
) (
  input  logic                                          iTCK,
  input  logic                                          iRST_N,
  input  logic                                          iTDI,
  input  logic                                          iSTATE_CDR,
  input  logic                                          iSTATE_SDR,
  input  logic                                          iSTATE_UDR,
  input  logic [2*ADDRESS_WIDTH:0]                      iADDRESS,
  input  logic [NUMBER_OF_REGISTERS*REGISTER_SIZE-1:0]  iDATA,
  output logic [NUMBER_OF_REGISTERS*REGISTER_SIZE-1:0]  oDATA,
  output logic                                          oTDO,
  output logic [NUMBER_OF_REGISTERS-1:0]                oWRITE_STROBE,
  output logic [NUMBER_OF_REGISTERS-1:0]                oREAD_STROBE
);

  localparam int RS = REGISTER_SIZE;
  localparam int N  = NUMBER_OF_REGISTERS;
  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] ALL_ONES = {AW{1'b1}};

  logic [N*RS-1:0]       mem_r;
  logic [RS-1:0]         work_r;
  logic [IDREG_SIZE-1:0] id_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic                  armed_r;
  logic                  id_mode_r;
  logic [N-1:0]          wr_strobe_r;
  logic [N-1:0]          rd_strobe_r;

  logic                  en_s;
  logic [AW-1:0]         wr_idx_s;
  logic [AW-1:0]         rd_idx_s;
  logic                  cdr_s;
  logic                  sdr_s;
  logic                  udr_s;
  logic                  commit_s;
  logic [RS-1:0]         shifted_s;

  // Pointer advance that sticks at the reserved all-ones index
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] p);
    if (p == ALL_ONES) begin
      sat_inc = p;
    end else begin
      sat_inc = p + AW'(1);
    end
  endfunction

  // One-hot strobe for an index; out-of-range indices give all zeros
  function automatic logic [N-1:0] onehot(input logic [AW-1:0] idx);
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == AW'(i)) onehot[i] = 1'b1;
    end
  endfunction

  // Word of a packed bus at an index; out-of-range indices read as zero
  function automatic logic [RS-1:0] pick(input logic [N*RS-1:0] bus,
                                         input logic [AW-1:0] idx);
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == AW'(i)) pick = bus[i*RS +: RS];
    end
  endfunction

  assign en_s     = iADDRESS[2*AW];
  assign wr_idx_s = iADDRESS[2*AW-1:AW];
  assign rd_idx_s = iADDRESS[AW-1:0];

  // Qualified state flags: enable gates everything, priority CDR > SDR > UDR
  always_comb begin
    cdr_s = en_s & iSTATE_CDR;
    sdr_s = en_s & iSTATE_SDR & armed_r & ~iSTATE_CDR;
    udr_s = en_s & iSTATE_UDR & armed_r & ~iSTATE_CDR & ~iSTATE_SDR;
  end

  // Work register after one shift; written bitwise so REGISTER_SIZE=1 works
  always_comb begin
    shifted_s         = work_r >> 1;
    shifted_s[RS-1]   = iTDI;
  end

  // Serial output: only meaningful while enabled and armed
  always_comb begin
    if (en_s && armed_r) begin
      oTDO = id_mode_r ? id_r[0] : work_r[0];
    end else begin
      oTDO = 1'b0;
    end
  end

  jtag_bit_counter #(
    .REGISTER_SIZE (RS)
  ) u_bit_counter (
    .clk    (iTCK),
    .rst_n  (iRST_N),
    .clear  (cdr_s),
    .step   (sdr_s),
    .commit (commit_s)
  );

  // Scan state, memory and strobes
  always_ff @(posedge iTCK) begin
    wr_strobe_r <= '0;
    rd_strobe_r <= '0;
    if (!iRST_N) begin
      mem_r     <= '0;
      work_r    <= '0;
      id_r      <= '0;
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      armed_r   <= 1'b0;
      id_mode_r <= 1'b0;
    end else if (cdr_s) begin
      armed_r   <= 1'b1;
      rd_ptr_r  <= rd_idx_s;
      wr_ptr_r  <= wr_idx_s;
      id_mode_r <= (rd_idx_s == ALL_ONES) && (wr_idx_s == ALL_ONES);
      if ((rd_idx_s == ALL_ONES) && (wr_idx_s == ALL_ONES)) begin
        id_r <= {JTAG_ID_VERSION, 8'(REGISTER_SIZE), 8'(NUMBER_OF_REGISTERS)};
      end else begin
        id_r <= '0;
      end
      work_r      <= pick(iDATA, rd_idx_s);
      rd_strobe_r <= onehot(rd_idx_s);
    end else if (sdr_s) begin
      work_r <= shifted_s;
      id_r   <= {1'b0, id_r[IDREG_SIZE-1:1]};
      if (commit_s) begin
        rd_ptr_r <= sat_inc(rd_ptr_r);
        wr_ptr_r <= sat_inc(wr_ptr_r);
        // Memory is never touched by an ID scan
        if (!id_mode_r) begin
          for (int i = 0; i < N; i++) begin
            if (wr_ptr_r == AW'(i)) mem_r[i*RS +: RS] <= shifted_s;
          end
          wr_strobe_r <= onehot(wr_ptr_r);
        end
`ifdef JTAG_REGBANK_BURST_EN
        work_r      <= pick(iDATA, sat_inc(rd_ptr_r));
        rd_strobe_r <= onehot(sat_inc(rd_ptr_r));
`endif
      end
    end else if (udr_s) begin
      armed_r <= 1'b0;
    end
  end

  assign oDATA         = mem_r;
  assign oWRITE_STROBE = wr_strobe_r;
  assign oREAD_STROBE  = rd_strobe_r;

endmodule

// File: tb/tb_jtag_regbank.sv
// tb_jtag_regbank: directed scans against jtag_regbank (8-bit x 3 registers).
// Stimulus pushes expected strobes and TDO words into queues; a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_jtag_regbank;

  logic        tck = 1'b0;
  logic        rst_n;
  logic        tdi;
  logic        cdr;
  logic        sdr;
  logic        udr;
  logic [4:0]  addr;
  logic [23:0] idata;
  logic [23:0] odata;
  logic        tdo;
  logic [2:0]  wstb;
  logic [2:0]  rstb;

  int total = 0;
  int bad   = 0;

  logic [26:0] wr_q[$];   // {strobe, oDATA}
  logic [2:0]  rd_q[$];
  logic [7:0]  tdo_q[$];

  logic [7:0]  acc;
  int          acc_n = 0;

  always #5 tck = ~tck;

  jtag_regbank #(
    .REGISTER_SIZE       (8),
    .NUMBER_OF_REGISTERS (3)
  ) dut (
    .iTCK          (tck),
    .iRST_N        (rst_n),
    .iTDI          (tdi),
    .iSTATE_CDR    (cdr),
    .iSTATE_SDR    (sdr),
    .iSTATE_UDR    (udr),
    .iADDRESS      (addr),
    .iDATA         (idata),
    .oDATA         (odata),
    .oTDO          (tdo),
    .oWRITE_STROBE (wstb),
    .oREAD_STROBE  (rstb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobes and completed TDO words against the queues
  always @(negedge tck) begin
    if (wstb !== 3'b000 && wstb !== 3'bxxx) begin
      if (wr_q.size() > 0) check("write_strobe_data", {wstb, odata}, wr_q.pop_front());
      else check("unexpected_write_strobe", wstb, 3'b000);
    end
    if (rstb !== 3'b000 && rstb !== 3'bxxx) begin
      if (rd_q.size() > 0) check("read_strobe", rstb, rd_q.pop_front());
      else check("unexpected_read_strobe", rstb, 3'b000);
    end
    if (!rst_n) begin
      acc_n = 0;
    end else begin
      if (cdr && addr[4]) acc_n = 0;
      if (sdr && addr[4]) begin
        acc = {tdo, acc[7:1]};
        acc_n++;
        if (acc_n == 8) begin
          acc_n = 0;
          if (tdo_q.size() > 0) check("tdo_word", acc, tdo_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic c, input logic s, input logic u, input logic t);
    cdr = c; sdr = s; udr = u; tdi = t;
    @(posedge tck);
    #1;
  endtask

  task automatic shift_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, d[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tdi = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
    addr = 5'b1_00_01; idata = 24'h5A_A5_0F;
    @(posedge tck); #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_odata", odata, 24'h0);
    check("reset_wstb", wstb, 3'b000);
    check("reset_rstb", rstb, 3'b000);
    check("reset_tdo", tdo, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // ID request: 24 bits LSB first, no strobes, memory untouched
    addr = 5'b1_11_11;
    tdo_q.push_back(8'h03); tdo_q.push_back(8'h08); tdo_q.push_back(8'h02);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_word(8'hFF); shift_word(8'hA5); shift_word(8'h5A);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("id_odata", odata, 24'h0);
    check("id_tdo_after_udr", tdo, 1'b0);

    // Single access: read reg1 (0xA5), write reg0 with 0x3C
    addr = 5'b1_00_01;
    rd_q.push_back(3'b010);
    tdo_q.push_back(8'hA5);
    wr_q.push_back({3'b001, 24'h00_00_3C});
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_word(8'h3C);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("single_odata", odata, 24'h00_00_3C);

    // Overrun: read/write reg2, 16 bits; only reg2 written
    addr = 5'b1_10_10;
    rd_q.push_back(3'b100);
    tdo_q.push_back(8'h5A);
`ifdef JTAG_REGBANK_BURST_EN
    tdo_q.push_back(8'h00);
`else
    tdo_q.push_back(8'h96);
`endif
    wr_q.push_back({3'b100, 24'h96_00_3C});
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_word(8'h96); shift_word(8'hC3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("overrun_odata", odata, 24'h96_00_3C);

    // Partial scan then UDR: nothing written
    addr = 5'b1_01_00;
    rd_q.push_back(3'b001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("partial_odata", odata, 24'h96_00_3C);

    // Reset mid-scan: aborted, everything back to zero, SDR ignored after
    rd_q.push_back(3'b001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    check("midreset_odata", odata, 24'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check("midreset_tdo", tdo, 1'b0);
    end
    check("postreset_odata", odata, 24'h0);
    check("postreset_strobes", {wstb, rstb}, 6'b0);

    // Enable bit clear: scan has no effect, TDO held at 0
    addr = 5'b0_00_01;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check("disabled_tdo", tdo, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("disabled_odata", odata, 24'h0);

    // Three-word scan from reg0
    addr = 5'b1_00_00; idata = 24'h33_22_11;
    rd_q.push_back(3'b001);
`ifdef JTAG_REGBANK_BURST_EN
    rd_q.push_back(3'b010); rd_q.push_back(3'b100);
    tdo_q.push_back(8'h11); tdo_q.push_back(8'h22); tdo_q.push_back(8'h33);
    wr_q.push_back({3'b001, 24'h00_00_11});
    wr_q.push_back({3'b010, 24'h00_22_11});
    wr_q.push_back({3'b100, 24'h33_22_11});
`else
    tdo_q.push_back(8'h11); tdo_q.push_back(8'h11); tdo_q.push_back(8'h22);
    wr_q.push_back({3'b001, 24'h00_00_11});
`endif
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_word(8'h11); shift_word(8'h22); shift_word(8'h33);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef JTAG_REGBANK_BURST_EN
    check("multi_odata", odata, 24'h33_22_11);
`else
    check("multi_odata", odata, 24'h00_00_11);
`endif
    check("multi_tdo_after_udr", tdo, 1'b0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("write_queue_drained", wr_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);
    check("tdo_queue_drained", tdo_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
